// File: rtl/mem_port_arbiter.sv
// Two-requester (core/loader) arbiter onto a single memory port.
// Round-robin on ties, bounded wait with abort, one IDLE turnaround per access.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_done,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_stall,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_done,
  output logic [DATA_W-1:0] l_rdata,
  output logic              l_stall,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ready,
  output logic              err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_C = 2'd1,
    BUSY_L = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_last_l;
  logic [CNT_W-1:0]    r_wait;
  logic                r_m_en;
  logic                r_m_we;
  logic [ADDR_W-1:0]   r_m_addr;
  logic [DATA_W-1:0]   r_m_wdata;
  logic                r_c_done;
  logic                r_l_done;
  logic                r_err;
  logic [DATA_W-1:0]   r_c_rdata;
  logic [DATA_W-1:0]   r_l_rdata;
  logic                w_c_elig;
  logic                w_l_elig;
  logic                w_grant_c;
  logic                w_grant_l;
  logic                w_busy;
  logic                w_complete;
  logic                w_abort;
  logic                w_finish;

  // A requester whose done is showing still has req high; mask it so the
  // turnaround cycle cannot re-grant the access that just finished.
  assign w_c_elig   = c_req & ~r_c_done;
  assign w_l_elig   = l_req & ~r_l_done;
  assign w_busy     = (r_state != IDLE);
  assign w_complete = w_busy & m_ready;
  assign w_abort    = w_busy & ~m_ready & (r_wait == LAST_WAIT);
  assign w_finish   = w_complete | w_abort;

  // Next-state and grant decode.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_c   = 1'b0;
    w_grant_l   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_c_elig && (!w_l_elig || r_last_l)) begin
          w_state_nxt = BUSY_C;
          w_grant_c   = 1'b1;
        end else if (w_l_elig) begin
          w_state_nxt = BUSY_L;
          w_grant_l   = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      BUSY_C, BUSY_L: begin
        if (w_finish) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Memory-side request registers, wait counter and round-robin pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_m_en    <= 1'b0;
      r_m_we    <= 1'b0;
      r_m_addr  <= {ADDR_W{1'b0}};
      r_m_wdata <= {DATA_W{1'b0}};
      r_wait    <= {CNT_W{1'b0}};
      r_last_l  <= 1'b1;
    end else begin
      r_m_en <= (w_state_nxt != IDLE);
      if (w_grant_c) begin
        r_m_we    <= c_we;
        r_m_addr  <= c_addr;
        r_m_wdata <= c_wdata;
      end else if (w_grant_l) begin
        r_m_we    <= l_we;
        r_m_addr  <= l_addr;
        r_m_wdata <= l_wdata;
      end
      if (w_grant_c || w_grant_l) begin
        r_wait <= {CNT_W{1'b0}};
      end else if (w_busy && !m_ready && !w_abort) begin
        r_wait <= r_wait + CNT_W'(1);
      end
      if (w_finish) begin
        r_last_l <= (r_state == BUSY_L);
      end
    end
  end

  // Completion pulses and read-data capture (reads that complete normally only).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_c_done  <= 1'b0;
      r_l_done  <= 1'b0;
      r_err     <= 1'b0;
      r_c_rdata <= {DATA_W{1'b0}};
      r_l_rdata <= {DATA_W{1'b0}};
    end else begin
      r_c_done <= w_finish & (r_state == BUSY_C);
      r_l_done <= w_finish & (r_state == BUSY_L);
      r_err    <= w_abort;
      if (w_complete && !r_m_we && (r_state == BUSY_C)) begin
        r_c_rdata <= m_rdata;
      end
      if (w_complete && !r_m_we && (r_state == BUSY_L)) begin
        r_l_rdata <= m_rdata;
      end
    end
  end

  assign m_en    = r_m_en;
  assign m_we    = r_m_we;
  assign m_addr  = r_m_addr;
  assign m_wdata = r_m_wdata;
  assign c_done  = r_c_done;
  assign l_done  = r_l_done;
  assign err     = r_err;
  assign c_rdata = r_c_rdata;
  assign l_rdata = r_l_rdata;
  assign c_stall = c_req & ~r_c_done;
  assign l_stall = l_req & ~r_l_done;

endmodule
